// File: rtl/dff8_pkg.sv
// dff8 shared constants.
// Default width and reset value for the byte register.
package dff8_pkg;

    localparam int DFF8_WIDTH = 8;
    localparam logic [DFF8_WIDTH-1:0] DFF8_RESET = '0;

endpackage

// File: rtl/dff8.sv
// dff8: positive-edge D register bank.
// Asynchronous active-high clear to RESET_VALUE.
module dff8
    import dff8_pkg::*;
#(
    parameter int WIDTH = DFF8_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF8_RESET)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Declaration init gives a defined power-up value before any edge.
    logic [WIDTH-1:0] q_r = RESET_VALUE;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_dff8.sv
// tb_dff8: randomized scoreboard bench for dff8.
// Model pushes expected q per rising edge; monitor pops and compares.
module tb_dff8;

    localparam logic [7:0] RV = 8'h00;

    logic       clk;
    logic       areset;
    logic [7:0] d;
    logic [7:0] q;

    int total  = 0;
    int passed = 0;
    bit done   = 0;

    logic [7:0] exp_q[$];

    dff8 dut (
        .clk    (clk),
        .areset (areset),
        .d      (d),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: q=%h expected=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: after each rising edge q is d sampled before it,
    // or the reset value if areset was high at that edge.
    always @(posedge clk) begin
        if (!done) begin
            exp_q.push_back(areset ? RV : d);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (!done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                chk("edge", q, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b0;
        d      = 8'h00;

        #1;
        chk("powerup", q, RV);
        d = 8'hA5;

        @(negedge clk);
        d = 8'h3C;
        #1;
        chk("hold_fall", q, 8'hA5);

        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #2 d = 8'($urandom);
            @(negedge clk);
            d = 8'($urandom);
        end

        @(negedge clk);
        d = 8'hFF;
        @(posedge clk);
        #2;
        chk("load_ff", q, 8'hFF);
        #1 areset = 1'b1;
        #1;
        chk("async_clr", q, RV);
        d = 8'h77;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_hold", q, RV);

        @(negedge clk);
        #1 areset = 1'b0;
        #1;
        chk("deassert_hold", q, RV);
        @(posedge clk);
        #2;
        chk("first_capture", q, 8'h77);

        @(negedge clk);
        d = 8'h80;
        @(posedge clk);
        #2;
        chk("msb", q, 8'h80);
        @(negedge clk);
        d = 8'h01;
        @(posedge clk);
        #2;
        chk("lsb", q, 8'h01);

        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2 d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                #1 areset = 1'b1;
                #1;
                chk("rand_clr", q, RV);
                @(negedge clk);
                #1 areset = 1'b0;
            end
            @(negedge clk);
            d = 8'($urandom);
        end

        @(posedge clk);
        #3 done = 1'b1;
        total++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: left=%0d expected=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
